// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage between decode and execute.
//
// Holds the architectural NZCV flag register, evaluates the ARM condition
// field of the decode-stage instruction and registers the condition-gated
// write/branch requests into the execute stage. Flags produced by the ALU
// are committed when the flag-setting instruction leaves execute.
//
// Optional build macro: COND_UNIT_FLAG_FWD_EN
//   defined   - condition evaluation sees ALU flags forwarded per group from
//               the flag-setting instruction currently in execute.
//   undefined - condition evaluation sees only the committed Flags register;
//               an instruction directly after a flag-setter sees stale flags.
//
// Ports:
//   CLK        clock, rising edge
//   RESETn     asynchronous active-low reset
//   Cond       condition field of the decode-stage instruction
//   InValid    decode-stage instruction valid
//   Stall      hold the execute-stage register
//   Flush      kill the instruction entering execute (wins over Stall)
//   PCS, RegW, MemW, NoWrite, FlagW   raw decoder requests
//   ALUFlags   {N,Z,C,V} from the ALU for the execute-stage instruction
//   PCSrcE, RegWriteE, MemWriteE, CondExE, FlagWE   registered execute outputs
//   Flags      committed NZCV register

module cond_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [3:0] Cond,
    input  logic       InValid,
    input  logic       Stall,
    input  logic       Flush,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic [1:0] FlagW,
    input  logic [3:0] ALUFlags,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       CondExE,
    output logic [1:0] FlagWE,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic [3:0] eval_flags;
    logic       cond_ex;
    logic       ex;
    logic       n_f, z_f, c_f, v_f;
    logic       commit;

`ifdef COND_UNIT_FLAG_FWD_EN
    // Forward each flag group independently from the instruction in execute.
    assign eval_flags[3:2] = FlagWE[1] ? ALUFlags[3:2] : flags_q[3:2];
    assign eval_flags[1:0] = FlagWE[0] ? ALUFlags[1:0] : flags_q[1:0];
`else
    assign eval_flags = flags_q;
`endif

    assign n_f = eval_flags[3];
    assign z_f = eval_flags[2];
    assign c_f = eval_flags[1];
    assign v_f = eval_flags[0];

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // 1111: never executes
        endcase
    end

    assign ex = cond_ex & InValid;

    // The execute instruction leaves on any edge that is not a pure stall;
    // a flush still lets the current execute instruction retire its flags.
    assign commit = !Stall || Flush;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            PCSrcE    <= 1'b0;
            RegWriteE <= 1'b0;
            MemWriteE <= 1'b0;
            CondExE   <= 1'b0;
            FlagWE    <= 2'b00;
        end else if (Flush) begin
            PCSrcE    <= 1'b0;
            RegWriteE <= 1'b0;
            MemWriteE <= 1'b0;
            CondExE   <= 1'b0;
            FlagWE    <= 2'b00;
        end else if (!Stall) begin
            PCSrcE    <= PCS & ex;
            RegWriteE <= RegW & !NoWrite & ex;
            MemWriteE <= MemW & ex;
            CondExE   <= ex;
            FlagWE    <= FlagW & {2{ex}};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            flags_q <= FLAG_RST;
        end else if (commit) begin
            if (FlagWE[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagWE[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic [3:0] Cond;
    logic       InValid, Stall, Flush, PCS, RegW, MemW, NoWrite;
    logic [1:0] FlagW;
    logic [3:0] ALUFlags;
    logic       PCSrcE, RegWriteE, MemWriteE, CondExE;
    logic [1:0] FlagWE;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;

    cond_unit #(.FLAG_RST(4'b0000)) dut (
        .CLK(CLK), .RESETn(RESETn), .Cond(Cond), .InValid(InValid),
        .Stall(Stall), .Flush(Flush), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .FlagW(FlagW), .ALUFlags(ALUFlags),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .CondExE(CondExE), .FlagWE(FlagWE), .Flags(Flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Cond = 4'b1110; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; FlagW = 2'b00;
    endtask

    // Load the flag register through a CMP-like AL instruction followed by
    // its commit edge. Leaves FlagWE=00 and Flags=v.
    task automatic set_flags(input logic [3:0] v);
        idle();
        InValid = 1'b1; NoWrite = 1'b1; FlagW = 2'b11;
        step();
        idle();
        ALUFlags = v;
        step();
    endtask

    initial begin
        // Condition sweep vectors: {flags, cond, expected CondExE}
        vecs[0]  = '{4'b1001, 4'b1010, 1'b1}; // GE
        vecs[1]  = '{4'b1001, 4'b1100, 1'b1}; // GT
        vecs[2]  = '{4'b1001, 4'b0100, 1'b1}; // MI
        vecs[3]  = '{4'b1001, 4'b1011, 1'b0}; // LT
        vecs[4]  = '{4'b1001, 4'b1101, 1'b0}; // LE
        vecs[5]  = '{4'b1001, 4'b0101, 1'b0}; // PL
        vecs[6]  = '{4'b0010, 4'b1000, 1'b1}; // HI
        vecs[7]  = '{4'b0010, 4'b1001, 1'b0}; // LS
        vecs[8]  = '{4'b0010, 4'b1111, 1'b0}; // never
        vecs[9]  = '{4'b1111, 4'b1111, 1'b0}; // never, all flags set
        vecs[10] = '{4'b0100, 4'b0000, 1'b1}; // EQ
        vecs[11] = '{4'b0100, 4'b0001, 1'b0}; // NE
        vecs[12] = '{4'b0010, 4'b0010, 1'b1}; // CS
        vecs[13] = '{4'b0010, 4'b0011, 1'b0}; // CC
        vecs[14] = '{4'b0001, 4'b0110, 1'b1}; // VS
        vecs[15] = '{4'b0001, 4'b0111, 1'b0}; // VC
        vecs[16] = '{4'b0000, 4'b1110, 1'b1}; // AL
        vecs[17] = '{4'b0110, 4'b1100, 1'b0}; // GT with Z=1

        idle();
        ALUFlags = 4'b0000;
        RESETn = 1'b0;
        #12;
        check("reset_flags", Flags, 4'b0000);
        check("reset_eout", {PCSrcE, RegWriteE, MemWriteE, CondExE}, 4'b0000);
        RESETn = 1'b1;
        #3;

        // Table-driven condition sweep with full gating
        for (int i = 0; i < 18; i++) begin
            set_flags(vecs[i].flags);
            check($sformatf("flags_load_%0d", i), Flags, vecs[i].flags);
            idle();
            Cond = vecs[i].cond; InValid = 1'b1;
            PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b00;
            step();
            check($sformatf("cond_%0d_condex", i), {3'b000, CondExE}, {3'b000, vecs[i].exp});
            check($sformatf("cond_%0d_gated", i), {1'b0, PCSrcE, RegWriteE, MemWriteE},
                  {1'b0, {3{vecs[i].exp}}});
        end

        // Async reset mid-operation, including during a stall
        set_flags(4'b1111);
        idle();
        InValid = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11;
        step();
        check("pre_reset_regw", {3'b000, RegWriteE}, 4'b0001);
        Stall = 1'b1;
        #2;
        RESETn = 1'b0;
        #1;
        check("async_reset_flags", Flags, 4'b0000);
        check("async_reset_eout", {PCSrcE, RegWriteE, MemWriteE, CondExE}, 4'b0000);
        check("async_reset_flagwe", {2'b00, FlagWE}, 4'b0000);
        idle();
        #4;
        RESETn = 1'b1;
        Cond = 4'b0000; InValid = 1'b1; PCS = 1'b1;
        step();
        check("eq_after_reset", {2'b00, CondExE, PCSrcE}, 4'b0000);

        // CMP then BEQ back-to-back
        idle();
        InValid = 1'b1; NoWrite = 1'b1; RegW = 1'b1; FlagW = 2'b11;
        step();
        check("cmp_flagwe", {2'b00, FlagWE}, 4'b0011);
        check("cmp_no_regw", {3'b000, RegWriteE}, 4'b0000);
        idle();
        Cond = 4'b0000; InValid = 1'b1; PCS = 1'b1; ALUFlags = 4'b0100;
        step();
`ifdef COND_UNIT_FLAG_FWD_EN
        check("beq_fwd_pcsrc", {3'b000, PCSrcE}, 4'b0001);
`else
        check("beq_stale_pcsrc", {3'b000, PCSrcE}, 4'b0000);
`endif
        check("cmp_commit", Flags, 4'b0100);

        // Failed condition gates everything, flags untouched
        set_flags(4'b0100);
        idle();
        Cond = 4'b0001; InValid = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11;
        ALUFlags = 4'b1011;
        step();
        check("gate_outputs", {1'b0, RegWriteE, MemWriteE, CondExE}, 4'b0000);
        check("gate_flagwe", {2'b00, FlagWE}, 4'b0000);
        idle();
        step();
        check("gate_flags_hold", Flags, 4'b0100);

        // Stall holds outputs and blocks commit; release commits C,V only
        set_flags(4'b0000);
        idle();
        InValid = 1'b1; RegW = 1'b1; FlagW = 2'b01;
        step();
        check("stall_setup", {RegWriteE, 1'b0, FlagWE}, 4'b1001);
        idle();
        Stall = 1'b1; ALUFlags = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall_hold_%0d", c), {RegWriteE, 1'b0, FlagWE}, 4'b1001);
            check($sformatf("stall_nocommit_%0d", c), Flags, 4'b0000);
        end
        Stall = 1'b0;
        step();
        check("stall_release_commit", Flags, 4'b0011);
        check("stall_release_adv", {RegWriteE, 1'b0, FlagWE}, 4'b0000);

        // Flush with Stall: clears E outputs and commits on the same edge
        idle();
        InValid = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11;
        step();
        check("flush_setup", {PCSrcE, RegWriteE, MemWriteE, CondExE}, 4'b1111);
        Stall = 1'b1; Flush = 1'b1; ALUFlags = 4'b1010;
        step();
        check("flush_clear", {PCSrcE, RegWriteE, MemWriteE, CondExE}, 4'b0000);
        check("flush_flagwe", {2'b00, FlagWE}, 4'b0000);
        check("flush_commit", Flags, 4'b1010);

        // Partial flag write: N,Z group only
        set_flags(4'b1111);
        idle();
        InValid = 1'b1; NoWrite = 1'b1; FlagW = 2'b10;
        step();
        idle();
        ALUFlags = 4'b0000;
        step();
        check("partial_nz", Flags, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
